// File: rtl/cplx_acc_pkg.sv
// Shared types and constants for the complex dot-product accumulator.
package cplx_acc_pkg;

    typedef enum logic [1:0] {S_GET, S_ADD, S_PUT} acc_state_t;

    localparam int DBL_W = 64;
    localparam logic [DBL_W-1:0] DBL_ZERO = 64'h0;

    typedef logic [DBL_W-1:0] dbl_t;

endpackage

// File: rtl/double_adder.sv
// IEEE-754 double adder, round-to-nearest-even, with stb/ack handshakes on both inputs and the result.
// Inputs are taken together once both strobes are up; the sum is held on output_z until acked.
module double_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [63:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        logic        sa, sb, sz, ts;
        logic [10:0] xa, xb;
        logic [51:0] fa, fb;
        logic [55:0] ma, mb, tm;
        logic [12:0] ea, eb, ez, tx, d;
        logic [56:0] s;
        logic [53:0] m;
        logic        up;
        sa = a[63]; xa = a[62:52]; fa = a[51:0];
        sb = b[63]; xb = b[62:52]; fb = b[51:0];
        if ((xa == 11'h7FF && fa != '0) || (xb == 11'h7FF && fb != '0))
            return 64'h7FF8000000000000;
        if (xa == 11'h7FF) begin
            if (xb == 11'h7FF && sa != sb)
                return 64'h7FF8000000000000;
            return a;
        end
        if (xb == 11'h7FF)
            return b;
        if (xa == 11'd0 && fa == '0) begin
            if (xb == 11'd0 && fb == '0)
                return {sa & sb, 63'h0};
            return b;
        end
        if (xb == 11'd0 && fb == '0)
            return a;
        ma = {(xa != 11'd0), fa, 3'b000};
        mb = {(xb != 11'd0), fb, 3'b000};
        ea = (xa == 11'd0) ? 13'd1 : {2'b00, xa};
        eb = (xb == 11'd0) ? 13'd1 : {2'b00, xb};
        if (eb > ea) begin
            tm = ma; ma = mb; mb = tm;
            tx = ea; ea = eb; eb = tx;
            ts = sa; sa = sb; sb = ts;
        end
        d = ea - eb;
        // bits shifted out of the smaller operand collapse into the sticky bit
        for (int i = 0; i < 56; i++)
            if (13'(i) < d)
                mb = (mb >> 1) | {55'b0, mb[0]};
        if (sa == sb) begin
            s = {1'b0, ma} + {1'b0, mb}; sz = sa;
        end else if (ma >= mb) begin
            s = {1'b0, ma} - {1'b0, mb}; sz = sa;
        end else begin
            s = {1'b0, mb} - {1'b0, ma}; sz = sb;
        end
        if (s == '0)
            return 64'h0;
        ez = ea;
        if (s[56]) begin
            s  = (s >> 1) | {56'b0, s[0]};
            ez = ez + 13'd1;
        end
        for (int i = 0; i < 56; i++)
            if (!s[55] && ez > 13'd1) begin
                s  = s << 1;
                ez = ez - 13'd1;
            end
        up = s[2] & (s[1] | s[0] | s[3]);
        m  = {1'b0, s[55:3]} + {53'b0, up};
        if (m[53]) begin
            m  = m >> 1;
            ez = ez + 13'd1;
        end
        if (ez >= 13'd2047)
            return {sz, 11'h7FF, 52'h0};
        // hidden bit clear after normalisation means the result is subnormal
        return {sz, (m[52] ? ez[10:0] : 11'h0), m[51:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z     <= 64'h0;
            output_z_stb <= 1'b0;
        end else begin
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b0;
            if (output_z_stb) begin
                if (output_z_ack)
                    output_z_stb <= 1'b0;
            end else if (input_a_stb && input_b_stb && !input_a_ack) begin
                input_a_ack  <= 1'b1;
                input_b_ack  <= 1'b1;
                output_z     <= fadd(input_a, input_b);
                output_z_stb <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/complex_dot_accumulator.sv
// Sums LENGTH complex double products into one dot-product element, then emits it.
// Defining CPLX_ACC_DEBUG_EN adds the dbg_cnt and dbg_busy observation ports.
//
// state | meaning
// S_GET | wait for both product halves, accept them together
// S_ADD | both lane adders working on (acc, term)
// S_PUT | element presented, waiting for each lane to be acked
module complex_dot_accumulator
    import cplx_acc_pkg::*;
#(
    parameter int LENGTH = 4,
    parameter int CNT_W  = $clog2(LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  dbl_t             in_real,
    input  logic             in_real_stb,
    output logic             in_real_ack,
    input  dbl_t             in_imag,
    input  logic             in_imag_stb,
    output logic             in_imag_ack,
    output dbl_t             out_real,
    output logic             out_real_stb,
    input  logic             out_real_ack,
    output dbl_t             out_imag,
    output logic             out_imag_stb,
    input  logic             out_imag_ack
`ifdef CPLX_ACC_DEBUG_EN
    ,
    output logic [CNT_W-1:0] dbg_cnt,
    output logic             dbg_busy
`endif
);

    if (LENGTH < 1) begin : g_length_check
        $error("complex_dot_accumulator: LENGTH must be >= 1");
    end

    acc_state_t state, state_d;
    dbl_t acc_re, acc_im, term_re, term_im, add_z_re, add_z_im;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic last, take, absorb, real_fire, imag_fire, put_end, res_ack;
    logic a_done_re, b_done_re, a_done_im, b_done_im, put_done_re, put_done_im;
    logic add_a_stb_re, add_b_stb_re, add_a_ack_re, add_b_ack_re, add_z_stb_re;
    logic add_a_stb_im, add_b_stb_im, add_a_ack_im, add_b_ack_im, add_z_stb_im;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign last     = (cnt_inc == CNT_W'(LENGTH));
    assign out_real = acc_re;
    assign out_imag = acc_im;

    always_comb begin
        state_d      = state;
        take         = (state == S_GET) && in_real_stb && in_imag_stb && !in_real_ack;
        absorb       = (state == S_ADD) && add_z_stb_re && add_z_stb_im && !res_ack;
        out_real_stb = (state == S_PUT) && !put_done_re;
        out_imag_stb = (state == S_PUT) && !put_done_im;
        real_fire    = out_real_stb && out_real_ack;
        imag_fire    = out_imag_stb && out_imag_ack;
        put_end      = (state == S_PUT) && (put_done_re || real_fire) && (put_done_im || imag_fire);
        add_a_stb_re = (state == S_ADD) && !a_done_re;
        add_b_stb_re = (state == S_ADD) && !b_done_re;
        add_a_stb_im = (state == S_ADD) && !a_done_im;
        add_b_stb_im = (state == S_ADD) && !b_done_im;
        case (state)
            S_GET: if (take) begin
                // the first term is loaded directly so -0.0 and NaN payloads survive
                if (cnt != '0)
                    state_d = S_ADD;
                else if (last)
                    state_d = S_PUT;
            end
            S_ADD: if (absorb) state_d = last ? S_PUT : S_GET;
            S_PUT: if (put_end) state_d = S_GET;
            default: state_d = S_GET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_GET;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re      <= DBL_ZERO;
            acc_im      <= DBL_ZERO;
            term_re     <= DBL_ZERO;
            term_im     <= DBL_ZERO;
            cnt         <= '0;
            in_real_ack <= 1'b0;
            in_imag_ack <= 1'b0;
            res_ack     <= 1'b0;
            a_done_re   <= 1'b0;
            b_done_re   <= 1'b0;
            a_done_im   <= 1'b0;
            b_done_im   <= 1'b0;
            put_done_re <= 1'b0;
            put_done_im <= 1'b0;
        end else begin
            in_real_ack <= take;
            in_imag_ack <= take;
            res_ack     <= absorb;
            if (take) begin
                term_re <= in_real;
                term_im <= in_imag;
                if (cnt == '0) begin
                    acc_re <= in_real;
                    acc_im <= in_imag;
                    cnt    <= cnt_inc;
                end
            end
            if (add_a_ack_re) a_done_re <= 1'b1;
            if (add_b_ack_re) b_done_re <= 1'b1;
            if (add_a_ack_im) a_done_im <= 1'b1;
            if (add_b_ack_im) b_done_im <= 1'b1;
            if (absorb) begin
                acc_re    <= add_z_re;
                acc_im    <= add_z_im;
                cnt       <= cnt_inc;
                a_done_re <= 1'b0;
                b_done_re <= 1'b0;
                a_done_im <= 1'b0;
                b_done_im <= 1'b0;
            end
            if (real_fire) put_done_re <= 1'b1;
            if (imag_fire) put_done_im <= 1'b1;
            if (put_end) begin
                acc_re      <= DBL_ZERO;
                acc_im      <= DBL_ZERO;
                cnt         <= '0;
                put_done_re <= 1'b0;
                put_done_im <= 1'b0;
            end
        end
    end

    double_adder acc_add_real (
        .clk(clk), .rst(rst),
        .input_a(acc_re),   .input_a_stb(add_a_stb_re), .input_a_ack(add_a_ack_re),
        .input_b(term_re),  .input_b_stb(add_b_stb_re), .input_b_ack(add_b_ack_re),
        .output_z(add_z_re), .output_z_stb(add_z_stb_re), .output_z_ack(res_ack)
    );

    double_adder acc_add_imag (
        .clk(clk), .rst(rst),
        .input_a(acc_im),   .input_a_stb(add_a_stb_im), .input_a_ack(add_a_ack_im),
        .input_b(term_im),  .input_b_stb(add_b_stb_im), .input_b_ack(add_b_ack_im),
        .output_z(add_z_im), .output_z_stb(add_z_stb_im), .output_z_ack(res_ack)
    );

`ifdef CPLX_ACC_DEBUG_EN
    assign dbg_cnt  = cnt;
    assign dbg_busy = (state == S_ADD);
`endif

endmodule

// File: tb/tb_complex_dot_accumulator.sv
// Bench for complex_dot_accumulator: a LENGTH=4 instance checked against a real-arithmetic model,
// plus a LENGTH=1 instance checked for bit-exact pass-through.
module tb_complex_dot_accumulator;
    import cplx_acc_pkg::*;

    localparam dbl_t D10 = 64'h4024000000000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    dbl_t in_real, in_imag, out_real, out_imag;
    logic in_real_stb, in_imag_stb, in_real_ack, in_imag_ack;
    logic out_real_stb, out_imag_stb, out_real_ack, out_imag_ack;

    dbl_t r1_in_real, r1_in_imag, r1_out_real, r1_out_imag;
    logic r1_in_real_stb, r1_in_imag_stb, r1_in_real_ack, r1_in_imag_ack;
    logic r1_out_real_stb, r1_out_imag_stb, r1_out_real_ack, r1_out_imag_ack;

`ifdef CPLX_ACC_DEBUG_EN
    logic [2:0] dbg_cnt4;
    logic dbg_busy4;
    logic [0:0] dbg_cnt1;
    logic dbg_busy1;
`endif

    complex_dot_accumulator #(.LENGTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_real(in_real), .in_real_stb(in_real_stb), .in_real_ack(in_real_ack),
        .in_imag(in_imag), .in_imag_stb(in_imag_stb), .in_imag_ack(in_imag_ack),
        .out_real(out_real), .out_real_stb(out_real_stb), .out_real_ack(out_real_ack),
        .out_imag(out_imag), .out_imag_stb(out_imag_stb), .out_imag_ack(out_imag_ack)
`ifdef CPLX_ACC_DEBUG_EN
        , .dbg_cnt(dbg_cnt4), .dbg_busy(dbg_busy4)
`endif
    );

    complex_dot_accumulator #(.LENGTH(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_real(r1_in_real), .in_real_stb(r1_in_real_stb), .in_real_ack(r1_in_real_ack),
        .in_imag(r1_in_imag), .in_imag_stb(r1_in_imag_stb), .in_imag_ack(r1_in_imag_ack),
        .out_real(r1_out_real), .out_real_stb(r1_out_real_stb), .out_real_ack(r1_out_real_ack),
        .out_imag(r1_out_imag), .out_imag_stb(r1_out_imag_stb), .out_imag_ack(r1_out_imag_ack)
`ifdef CPLX_ACC_DEBUG_EN
        , .dbg_cnt(dbg_cnt1), .dbg_busy(dbg_busy1)
`endif
    );

    int total = 0;
    int bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endfunction

    function automatic dbl_t r2b(input real r);
        return $realtobits(r);
    endfunction

    // model: plain double arithmetic, first term of each element taken as-is
    dbl_t exp_re_q[$], exp_im_q[$];
    dbl_t m_re, m_im;
    int m_cnt = 0;
    int n_out = 0;

    function automatic void model_add(input dbl_t re, input dbl_t im);
        if (m_cnt == 0) begin
            m_re = re;
            m_im = im;
        end else begin
            m_re = $realtobits($bitstoreal(m_re) + $bitstoreal(re));
            m_im = $realtobits($bitstoreal(m_im) + $bitstoreal(im));
        end
        m_cnt++;
        if (m_cnt == 4) begin
            exp_re_q.push_back(m_re);
            exp_im_q.push_back(m_im);
            m_cnt = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_real_stb) begin
                if (exp_re_q.size() == 0) fail_timeout("unexpected_out_real");
                else begin
                    chk("out_real_vs_model", out_real, exp_re_q[0]);
                    if (out_real_ack) begin
                        void'(exp_re_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (out_imag_stb) begin
                if (exp_im_q.size() == 0) fail_timeout("unexpected_out_imag");
                else begin
                    chk("out_imag_vs_model", out_imag, exp_im_q[0]);
                    if (out_imag_ack) void'(exp_im_q.pop_front());
                end
            end
        end
    end

    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (!rst && (in_real_ack || in_imag_ack)) begin
            chk("in_acks_together", {63'b0, in_imag_ack}, {63'b0, in_real_ack});
            chk("in_ack_one_cycle", {63'b0, prev_ack}, 64'h0);
            chk("in_ack_during_put", {62'b0, out_real_stb, out_imag_stb}, 64'h0);
        end
        prev_ack = in_real_ack || in_imag_ack;
    end

    logic hold_re = 1'b0, hold_im = 1'b0, spur_re = 1'b0;
    always @(posedge clk) begin
        #1;
        out_real_ack = (out_real_stb && !hold_re) || spur_re;
        out_imag_ack = out_imag_stb && !hold_im;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input dbl_t re, input dbl_t im, input bit chk_lat);
        int waited = 0;
        do begin
            tick();
            waited++;
        end while (!in_real_ack && !in_imag_ack && waited < 300);
        if (!(in_real_ack || in_imag_ack)) fail_timeout("accept_timeout");
        else begin
            model_add(re, im);
            if (chk_lat) chk("accept_latency", 64'(waited), 64'd1);
        end
        in_real_stb = 1'b0;
        in_imag_stb = 1'b0;
    endtask

    // skew > 0: real strobe leads by skew cycles; skew < 0: imag leads
    task automatic send(input dbl_t re, input dbl_t im, input int skew, input bit chk_lat);
        int n = (skew < 0) ? -skew : skew;
        in_real = re;
        in_imag = im;
        if (skew >= 0) in_real_stb = 1'b1; else in_imag_stb = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("no_ack_before_both", {63'b0, in_real_ack || in_imag_ack}, 64'h0);
        end
        in_real_stb = 1'b1;
        in_imag_stb = 1'b1;
        wait_ack(re, im, chk_lat);
    endtask

    task automatic wait_outputs();
        int waited = 0;
        while ((exp_re_q.size() != 0 || exp_im_q.size() != 0) && waited < 400) begin
            tick();
            waited++;
        end
        if (exp_re_q.size() != 0 || exp_im_q.size() != 0) fail_timeout("output_drain");
    endtask

    task automatic wait_out_check(input string name, input dbl_t re, input dbl_t im);
        int waited = 0;
        while (!out_real_stb && waited < 400) begin
            tick();
            waited++;
        end
        if (!out_real_stb) fail_timeout({name, "_out_timeout"});
        else begin
            chk({name, "_real"}, out_real, re);
            chk({name, "_imag"}, out_imag, im);
            chk({name, "_imag_stb"}, {63'b0, out_imag_stb}, 64'h1);
        end
        wait_outputs();
    endtask

    task automatic send1(input string name, input dbl_t re, input dbl_t im);
        int waited = 0;
        r1_in_real = re;
        r1_in_imag = im;
        r1_in_real_stb = 1'b1;
        r1_in_imag_stb = 1'b1;
        do begin
            tick();
            waited++;
        end while (!r1_in_real_ack && waited < 100);
        r1_in_real_stb = 1'b0;
        r1_in_imag_stb = 1'b0;
        if (!r1_in_real_ack) fail_timeout({name, "_accept"});
        else begin
            chk({name, "_imag_ack"}, {63'b0, r1_in_imag_ack}, 64'h1);
            chk({name, "_stb"}, {62'b0, r1_out_real_stb, r1_out_imag_stb}, 64'h3);
            chk({name, "_real"}, r1_out_real, re);
            chk({name, "_imag"}, r1_out_imag, im);
            r1_out_real_ack = 1'b1;
            r1_out_imag_ack = 1'b1;
            tick();
            r1_out_real_ack = 1'b0;
            r1_out_imag_ack = 1'b0;
            chk({name, "_stb_drop"}, {62'b0, r1_out_real_stb, r1_out_imag_stb}, 64'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=stalled required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst = 1'b1;
        in_real = '0; in_imag = '0; in_real_stb = 1'b0; in_imag_stb = 1'b0;
        r1_in_real = '0; r1_in_imag = '0; r1_in_real_stb = 1'b0; r1_in_imag_stb = 1'b0;
        r1_out_real_ack = 1'b0; r1_out_imag_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_out_stbs", {62'b0, out_real_stb, out_imag_stb}, 64'h0);
        chk("reset_out_real", out_real, 64'h0);
        chk("reset_out_imag", out_imag, 64'h0);
        chk("reset_in_acks", {62'b0, in_real_ack, in_imag_ack}, 64'h0);
        chk("reset1_out_stbs", {62'b0, r1_out_real_stb, r1_out_imag_stb}, 64'h0);
        chk("reset1_out_real", r1_out_real, 64'h0);

        // basic element, preceded by a stray output ack that must be ignored
        spur_re = 1'b1;
        repeat (2) tick();
        spur_re = 1'b0;
        send(r2b(1.0), r2b(1.0), 0, 1'b1);
        send(r2b(2.0), r2b(2.0), 0, 1'b0);
        send(r2b(3.0), r2b(3.0), 0, 1'b0);
        send(r2b(4.0), r2b(4.0), 0, 1'b0);
        wait_out_check("t1", D10, D10);

        // skewed strobes in both directions
        send(r2b(1.5), r2b(-0.5), 5, 1'b1);
        send(r2b(0.25), r2b(2.0), -3, 1'b0);
        send(r2b(-2.5), r2b(0.75), 0, 1'b0);
        send(r2b(0.1), r2b(0.2), 2, 1'b0);
        wait_outputs();

        // back-pressure on the real lane only
        hold_re = 1'b1;
        send(r2b(0.1), r2b(0.3), 0, 1'b0);
        send(r2b(0.2), r2b(0.7), 0, 1'b0);
        send(r2b(0.3), r2b(0.001), 0, 1'b0);
        send(r2b(-0.6), r2b(4.0), 0, 1'b0);
        begin
            int waited = 0;
            while (!out_real_stb && waited < 400) begin
                tick();
                waited++;
            end
            if (!out_real_stb) fail_timeout("bp_out_timeout");
        end
        in_real = r2b(1.0e16); in_imag = r2b(1.0);
        in_real_stb = 1'b1; in_imag_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_real_stb_held", {63'b0, out_real_stb}, 64'h1);
            chk("bp_imag_stb_dropped", {63'b0, out_imag_stb}, 64'h0);
            chk("bp_no_in_ack", {62'b0, in_real_ack, in_imag_ack}, 64'h0);
        end
        hold_re = 1'b0;
        wait_ack(r2b(1.0e16), r2b(1.0), 1'b0);
        send(r2b(1.0), r2b(-3.0), 0, 1'b0);
        send(r2b(-1.0e16), r2b(2.0), 0, 1'b0);
        send(r2b(3.0), r2b(0.5), 0, 1'b0);
        wait_outputs();

        // reset after two terms discards them
        send(r2b(5.0), r2b(5.0), 0, 1'b0);
        send(r2b(7.0), r2b(7.0), 0, 1'b0);
        tick();
        rst = 1'b1;
        m_cnt = 0;
        exp_re_q.delete();
        exp_im_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_out_stbs", {62'b0, out_real_stb, out_imag_stb}, 64'h0);
        send(r2b(1.0), r2b(1.0), 0, 1'b0);
        send(r2b(2.0), r2b(2.0), 0, 1'b0);
        send(r2b(3.0), r2b(3.0), 0, 1'b0);
        send(r2b(4.0), r2b(4.0), 0, 1'b0);
        wait_out_check("t4", D10, D10);

        // LENGTH=1 bit-exact pass-through
        send1("t5_negzero", 64'h8000000000000000, 64'hBFF0000000000000);
        send1("t5_nan", 64'h7FF0000000000001, 64'h7FF8000000000123);

        // cancellation, then two rounds back to back
        send(r2b(1.0), r2b(0.5), 0, 1'b0);
        send(r2b(-1.0), r2b(0.25), 0, 1'b0);
        send(r2b(2.0), r2b(0.125), 0, 1'b0);
        send(r2b(-2.0), r2b(0.0625), 0, 1'b0);
        wait_out_check("t6", 64'h0, 64'h3FEE000000000000);
        n0 = n_out;
        for (int r = 0; r < 2; r++) begin
            send(r2b(1.0), r2b(0.5), 0, 1'b0);
            send(r2b(-1.0), r2b(0.25), 0, 1'b0);
            send(r2b(2.0), r2b(0.125), 0, 1'b0);
            send(r2b(-2.0), r2b(0.0625), 0, 1'b0);
        end
        wait_outputs();
        repeat (5) tick();
        chk("t6_outputs_per_8_inputs", 64'(n_out - n0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
